// File: rtl/wb_regfile_if.sv
// W-stage bundle, D-stage read ports and the write-back status outputs of wb_regfile.
// The slave modport is the register file; the master modport drives the pipeline side.
interface wb_regfile_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      W_C;
  logic [31:0]      W_DR;
  logic [31:0]      W_PC;
  logic [31:0]      W_PC8;
  logic [31:0]      W_EXT;
  logic [31:0]      W_Instr;
  logic             W_check;
  logic [4:0]       D_A1;
  logic [4:0]       D_A2;
  logic [31:0]      D_RD1;
  logic [31:0]      D_RD2;
  logic [4:0]       W_A3;
  logic [31:0]      W_WD;
  logic             W_WE;
  logic [CNT_W-1:0] wb_count;

  modport slave (
    input  W_C, W_DR, W_PC, W_PC8, W_EXT, W_Instr, W_check, D_A1, D_A2,
    output D_RD1, D_RD2, W_A3, W_WD, W_WE, wb_count
  );

  modport master (
    output W_C, W_DR, W_PC, W_PC8, W_EXT, W_Instr, W_check, D_A1, D_A2,
    input  D_RD1, D_RD2, W_A3, W_WD, W_WE, wb_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: decodes the W-stage instruction and commits it into a 32x32 register file.
// Decode/reads are combinational with write-first bypass; writes and retire count land on the next posedge.
module wb_regfile #(
  parameter logic [5:0] COND_OP = 6'h3f,
  parameter int         CNT_W   = 32
) (
  input  logic        clk,
  input  logic        reset,
  wb_regfile_if.slave bus
);

  logic [5:0]       w_op;
  logic [5:0]       w_funct;
  logic [4:0]       w_rt;
  logic [4:0]       w_rd;
  logic             w_dec_we;
  logic [4:0]       w_dec_a3;
  logic [31:0]      w_dec_wd;
  logic             w_we;
  logic [4:0]       w_a3;
  logic [31:0]      w_wd;
  logic             w_unused_bits;

  logic [31:0]      r_regs [0:31];
  logic [CNT_W-1:0] r_wb_count;

  assign w_op    = bus.W_Instr[31:26];
  assign w_rt    = bus.W_Instr[20:16];
  assign w_rd    = bus.W_Instr[15:11];
  assign w_funct = bus.W_Instr[5:0];

  // PC is carried for debug visibility only; rs and shamt are not needed here.
  assign w_unused_bits = ^{bus.W_PC, bus.W_Instr[25:21], bus.W_Instr[10:6]};

  always_comb begin
    w_dec_we = 1'b0;
    w_dec_a3 = 5'd0;
    w_dec_wd = 32'd0;
    if (w_op == COND_OP) begin
      w_dec_we = bus.W_check;
      w_dec_a3 = w_rt;
      w_dec_wd = bus.W_C;
    end else begin
      case (w_op)
        6'h00: begin
          case (w_funct)
            6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h2b, 6'h00: begin
              w_dec_we = 1'b1;
              w_dec_a3 = w_rd;
              w_dec_wd = bus.W_C;
            end
            6'h09: begin
              w_dec_we = 1'b1;
              w_dec_a3 = w_rd;
              w_dec_wd = bus.W_PC8;
            end
            default: ;
          endcase
        end
        6'h0d, 6'h09, 6'h0c: begin
          w_dec_we = 1'b1;
          w_dec_a3 = w_rt;
          w_dec_wd = bus.W_C;
        end
        6'h0f: begin
          w_dec_we = 1'b1;
          w_dec_a3 = w_rt;
          w_dec_wd = bus.W_EXT;
        end
        6'h23: begin
          w_dec_we = 1'b1;
          w_dec_a3 = w_rt;
          w_dec_wd = bus.W_DR;
        end
        6'h03: begin
          w_dec_we = 1'b1;
          w_dec_a3 = 5'd31;
          w_dec_wd = bus.W_PC8;
        end
        default: ;
      endcase
    end
  end

  // A write aimed at $0 is squashed entirely so hazard logic never sees it.
  assign w_we = w_dec_we & (w_dec_a3 != 5'd0);
  assign w_a3 = w_we ? w_dec_a3 : 5'd0;
  assign w_wd = w_we ? w_dec_wd : 32'd0;

  assign bus.W_WE     = w_we;
  assign bus.W_A3     = w_a3;
  assign bus.W_WD     = w_wd;
  assign bus.wb_count = r_wb_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (w_we) begin
      r_regs[w_a3] <= w_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_count <= '0;
    end else if (bus.W_Instr != 32'd0) begin
      r_wb_count <= r_wb_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    bus.D_RD1 = r_regs[bus.D_A1];
    if (bus.D_A1 == 5'd0) begin
      bus.D_RD1 = 32'd0;
    end else if (w_we && (w_a3 == bus.D_A1)) begin
      bus.D_RD1 = w_wd;
    end
  end

  always_comb begin
    bus.D_RD2 = r_regs[bus.D_A2];
    if (bus.D_A2 == 5'd0) begin
      bus.D_RD2 = 32'd0;
    end else if (w_we && (w_a3 == bus.D_A2)) begin
      bus.D_RD2 = w_wd;
    end
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: takes the W-stage bundle (W_C, W_DR, W_PC8, W_EXT, W_Instr, W_check).
- Decodes the destination register and write-data source, then commits the result into a 32x32 general register file.
- Serves the two D-stage read ports with same-cycle write-first bypass.
- Exports W_A3/W_WD/W_WE for hazard/forwarding logic and keeps a retired-instruction counter for the bench.

Parameters:
- COND_OP, 6'h3f, opcode of the conditional-write I-type instruction gated by W_check.
- CNT_W, 32, width of retire counter.

Ports:
- clk  input  1  system clock, all state updates on posedge
- reset  input  1  synchronous active-high reset
- W_C  input  32  ALU result from MEM_WB
- W_DR  input  32  load data from MEM_WB
- W_PC  input  32  PC of W-stage instruction (debug only)
- W_PC8  input  32  PC+8 link value
- W_EXT  input  32  extended immediate (lui value)
- W_Instr  input  32  W-stage instruction word; 0 = bubble
- W_check  input  1  condition result for COND_OP instruction
- D_A1  input  5  D-stage read address 1 (rs)
- D_A2  input  5  D-stage read address 2 (rt)
- D_RD1  output  32  read data 1, combinational
- D_RD2  output  32  read data 2, combinational
- W_A3  output  5  decoded destination, 0 when no write
- W_WD  output  32  selected write data
- W_WE  output  1  effective write enable
- wb_count  output  CNT_W  number of retired non-bubble instructions

Behaviour:
- Decode is combinational from W_Instr. op=[31:26], rt=[20:16], rd=[15:11], funct=[5:0].
- Destination register and write-data source per instruction:
  - op 0, funct in {21 addu, 23 subu, 24 and, 25 or, 2a slt, 2b sltu, 00 sll}: A3=rd, WD=W_C.
  - op 0, funct 09 (jalr): A3=rd, WD=W_PC8.
  - op 0, funct 08 (jr) or any other funct: no write.
  - op 0d ori, 09 addiu, 0c andi: A3=rt, WD=W_C.
  - op 0f lui: A3=rt, WD=W_EXT.
  - op 23 lw: A3=rt, WD=W_DR.
  - op 03 jal: A3=31, WD=W_PC8.
  - op COND_OP: A3=rt, WD=W_C, write only if W_check=1. W_check is ignored for every other opcode.
  - All other opcodes (sw, beq, undefined): no write.
- When no write occurs: W_A3=0, W_WD=0, W_WE=0.
- W_WE = decoded write & (W_A3 != 0). Writes to $0 are never performed, and $0 always reads 0.
- Register write happens at posedge clk when W_WE=1 and reset=0. Write latency is 1 cycle.
- Read path: D_RDn = 0 if D_An=0. Otherwise, if W_WE=1 and W_A3==D_An, D_RDn = W_WD (write-first bypass, same cycle). Otherwise D_RDn = the stored register value.
- wb_count increments by 1 at posedge when W_Instr != 0 and reset=0.
  - It counts every retired non-bubble instruction, including non-writing ones and COND_OP with W_check=0.
  - It wraps modulo 2^CNT_W.
- Reset, synchronous and active-high:
  - All 32 registers and wb_count are cleared to 0 at the next posedge.
  - A write presented in the reset cycle is discarded.
  - Combinational outputs still reflect the current inputs during reset. After reset, D_RDn reads 0 for all addresses unless bypassed.
  - Reset asserted mid-stream behaves identically; no partial state survives.
- The W_PC input has no functional effect.

Test Plan:
- Reset, then W_Instr=ori $5,$0,0x1234 with W_C=0x1234 -> W_WE=1, W_A3=5, W_WD=0x1234. Same cycle, D_A1=5 gives D_RD1=0x1234 (bypass). Next cycle, with a bubble, D_RD1 is still 0x1234 and wb_count=1.
- Source select, one instruction each cycle with W_C=1, W_DR=2, W_EXT=3, W_PC8=4:
  - lw $6 -> reg6=2
  - lui $7 -> reg7=3
  - jal -> reg31=4
  - jalr rd=8 -> reg8=4
  - addu rd=9 -> reg9=1
- $0 protection: addu rd=0 with W_C=0xdeadbeef -> W_WE=0, W_A3=0. D_A2=0 gives 0. wb_count still increments.
- Conditional write: COND_OP rt=10, W_C=0x55, W_check=0 -> no write, reg10 unchanged. Repeat with W_check=1 -> reg10=0x55.
- Non-writers: sw, beq and jr with rt/rd=11 -> W_WE=0, reg11 unchanged. Bubble (W_Instr=0) -> wb_count unchanged.
- Reset mid-operation:
  - Load regs 1..31 with distinct values.
  - Assert reset for 1 cycle while W_Instr=ori $3 is presented.
  - Required: all reads return 0, wb_count=0, and the ori is not committed.
